axis_rr_arbiter: RTL and testbench
==================================

// Module: axis_rr_arbiter
// PURPOSE
//   Packet-level round-robin arbiter sharing one AXI-Stream output sink (e.g. output_module
//   slave port) between NUM_IN AXI-Stream requesters. Grant locks for a whole packet (until
//   TLAST beat accepted), then rotates. Registered output stage. Sits between router input
//   ports and the single per-node output/ejection module.
// PARAMETERS
//   NUM_IN   4   number of requesting streams (2..8)
//   TDATAW  32   data width
//   TDESTW   4   destination width
//   TIDW     2   ID width; must be >= $clog2(NUM_IN)
//   CNTW    16   width of PKT_CNT
// PORTS
//   CLK            in   1               clock, all logic rising-edge
//   RST            in   1               asynchronous, active-high reset
//   AXIS_S_TVALID  in   NUM_IN          per-requester valid
//   AXIS_S_TREADY  out  NUM_IN          per-requester ready (at most one bit set)
//   AXIS_S_TDATA   in   NUM_IN*TDATAW   requester i at [i*TDATAW +: TDATAW]
//   AXIS_S_TLAST   in   NUM_IN          end of packet
//   AXIS_S_TDEST   in   NUM_IN*TDESTW   requester i at [i*TDESTW +: TDESTW]
//   AXIS_M_TVALID  out  1               registered output valid
//   AXIS_M_TREADY  in   1               sink ready
//   AXIS_M_TDATA   out  TDATAW          registered data
//   AXIS_M_TLAST   out  1               registered last
//   AXIS_M_TID     out  TIDW            index of source requester, zero-extended
//   AXIS_M_TDEST   out  TDESTW          registered dest
//   GRANT          out  NUM_IN          one-hot current grant, 0 when IDLE
//   BUSY           out  1               1 while in LOCKED state
//   PKT_CNT        out  CNTW            packets delivered (TLAST handshakes on M side)
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=0, GRANT=0, BUSY=0, AXIS_S_TREADY=0, AXIS_M_TVALID=0,
//     AXIS_M_TDATA/TLAST/TID/TDEST=0, PKT_CNT=0. Reset mid-packet drops the packet; no resume.
//   FSM states: IDLE, LOCKED.
//   IDLE: if any S_TVALID, pick first set index scanning rr_ptr, rr_ptr+1, ... mod NUM_IN;
//     register GRANT/sel, -> LOCKED next cycle. No S_TREADY asserted in IDLE.
//   LOCKED: AXIS_S_TREADY[sel] = out_free, out_free = ~AXIS_M_TVALID | AXIS_M_TREADY
//     (combinational); all other TREADY bits 0. Beat accepted when TVALID[sel]&TREADY[sel]:
//     output regs load data/last/dest, TID=sel, M_TVALID=1 next cycle.
//   Accepted beat with TLAST=1: -> IDLE, rr_ptr = (sel+1) mod NUM_IN, GRANT=0.
//   Granted requester deasserting TVALID mid-packet: stay LOCKED, wait; no timeout.
//   Output reg: M_TVALID cleared when M_TREADY & no new beat loaded; held data stable while
//     M_TVALID & ~M_TREADY (AXIS rule). Simultaneous drain+load keeps M_TVALID=1.
//   Latency: request -> grant 1 cycle; accepted S beat -> M_TVALID 1 cycle.
//   Throughput: 1 beat/cycle within packet; exactly 1 IDLE bubble between packets.
//   Single-beat packet (TLAST on first beat) valid; LOCKED lasts one accept.
//   PKT_CNT increments on AXIS_M_TVALID & AXIS_M_TREADY & AXIS_M_TLAST; wraps 2^CNTW-1 -> 0.
//   Requests arriving while LOCKED wait; no preemption.
// STRUCTURE
//   noc_pkg: typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t; localparam NOC_TIDW.
//   Sub-module rr_pick #(N): combinational; inputs req[N], ptr; outputs one-hot gnt, idx,
//     any. Arbiter top holds FSM, rr_ptr, output register, counter.
// TESTING
//   Reset, S_TVALID=4'b1111 all 1-beat pkts -> M_TID order 0,1,2,3,0; 1 bubble between each.
//   Req0 3-beat pkt (A0,A1,A2) + req1 valid throughout -> M sees A0..A2 TID=0, then req1 pkt.
//   M_TREADY held 0 for 5 cycles mid-packet -> M_TDATA stable, S_TREADY[sel]=0, no beat lost.
//   Req2 drops TVALID 3 cycles mid-packet, req0 valid -> GRANT stays 4'b0100, BUSY=1.
//   RST pulsed mid-packet -> next cycle M_TVALID=0, GRANT=0, PKT_CNT=0, rr_ptr restarts at 0.
//   CNTW=4, send 17 packets -> PKT_CNT = 1 (wrap after 15 -> 0).

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC stream arbiter slice.
//   arb_state_t : arbiter FSM encoding (idle / locked to one requester)
//   NOC_TIDW    : default TID width on the merged output stream
package noc_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int NOC_TIDW = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index; priority falls off as ptr, ptr+1, ... mod N
//   gnt : one-hot winner (0 when no request)
//   idx : binary index of the winner (0 when no request)
//   any : at least one request present
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] pos;

    // Walk the offsets from farthest to nearest so the nearest requester
    // (lowest offset from ptr) is the last one written and therefore wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        pos = '0;
        any = |req;
        for (int k = N - 1; k >= 0; k--) begin
            pos = IW'((int'(ptr) + k) % N);
            if (req[pos]) begin
                gnt      = '0;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_IN AXI-Stream requesters share one
// AXI-Stream sink. A grant is held for a whole packet (until the TLAST beat
// is accepted), then priority rotates to the next index. Output is a single
// register stage.
//   CLK, RST            clock, asynchronous active-high reset
//   AXIS_S_*            packed requester streams (requester i at slice i)
//   AXIS_S_TREADY       at most one bit set, only while locked
//   AXIS_M_*            registered merged stream, TID = source index
//   GRANT               one-hot current grant, 0 when idle
//   BUSY                high while locked to a requester
//   PKT_CNT             packets delivered on the M side (wrapping)
//
// state      | meaning
// -----------+---------------------------------------------------------
// ARB_IDLE   | no owner; pick a requester from rr_ptr, no TREADY given
// ARB_LOCKED | owner sel forwards beats until its TLAST beat is accepted
module axis_rr_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int TDATAW = 32,
    parameter int TDESTW = 4,
    parameter int TIDW   = NOC_TIDW,
    parameter int CNTW   = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_IN-1:0]        AXIS_S_TVALID,
    output logic [NUM_IN-1:0]        AXIS_S_TREADY,
    input  logic [NUM_IN*TDATAW-1:0] AXIS_S_TDATA,
    input  logic [NUM_IN-1:0]        AXIS_S_TLAST,
    input  logic [NUM_IN*TDESTW-1:0] AXIS_S_TDEST,
    output logic                     AXIS_M_TVALID,
    input  logic                     AXIS_M_TREADY,
    output logic [TDATAW-1:0]        AXIS_M_TDATA,
    output logic                     AXIS_M_TLAST,
    output logic [TIDW-1:0]          AXIS_M_TID,
    output logic [TDESTW-1:0]        AXIS_M_TDEST,
    output logic [NUM_IN-1:0]        GRANT,
    output logic                     BUSY,
    output logic [CNTW-1:0]          PKT_CNT
);

    localparam int SELW = $clog2(NUM_IN);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [SELW-1:0]   sel;
    logic [SELW-1:0]   rr_ptr;
    logic [NUM_IN-1:0] grant_q;

    logic [NUM_IN-1:0] pick_gnt;
    logic [SELW-1:0]   pick_idx;
    logic              pick_any;

    logic              out_free;
    logic              accept;
    logic              sel_last;
    logic [TDATAW-1:0] sel_data;
    logic [TDESTW-1:0] sel_dest;

    rr_pick #(
        .N  (NUM_IN),
        .IW (SELW)
    ) u_pick (
        .req (AXIS_S_TVALID),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // The output register can take a beat when empty or draining this cycle.
    assign out_free = ~AXIS_M_TVALID | AXIS_M_TREADY;
    assign accept   = (state == ARB_LOCKED) & AXIS_S_TVALID[sel] & out_free;
    assign sel_last = AXIS_S_TLAST[sel];

    // grant_q is one-hot of sel while locked, so it doubles as the ready mask.
    assign AXIS_S_TREADY = (state == ARB_LOCKED && out_free) ? grant_q : '0;
    assign GRANT         = grant_q;
    assign BUSY          = (state == ARB_LOCKED);

    always_comb begin
        sel_data = '0;
        sel_dest = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SELW'(i)) begin
                sel_data = AXIS_S_TDATA[i*TDATAW +: TDATAW];
                sel_dest = AXIS_S_TDEST[i*TDESTW +: TDESTW];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:   if (pick_any)           state_nxt = ARB_LOCKED;
            ARB_LOCKED: if (accept && sel_last) state_nxt = ARB_IDLE;
            default:                            state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sel     <= '0;
            rr_ptr  <= '0;
            grant_q <= '0;
        end else if (state == ARB_IDLE && pick_any) begin
            sel     <= pick_idx;
            grant_q <= pick_gnt;
        end else if (accept && sel_last) begin
            grant_q <= '0;
            rr_ptr  <= (sel == SELW'(NUM_IN - 1)) ? '0 : sel + 1'b1;
        end
    end

    // Output stage: loading wins over draining so back-to-back beats keep
    // TVALID high; otherwise the register holds until the sink takes it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            AXIS_M_TVALID <= 1'b0;
            AXIS_M_TDATA  <= '0;
            AXIS_M_TLAST  <= 1'b0;
            AXIS_M_TID    <= '0;
            AXIS_M_TDEST  <= '0;
        end else if (accept) begin
            AXIS_M_TVALID <= 1'b1;
            AXIS_M_TDATA  <= sel_data;
            AXIS_M_TLAST  <= sel_last;
            AXIS_M_TID    <= TIDW'(sel);
            AXIS_M_TDEST  <= sel_dest;
        end else if (AXIS_M_TREADY) begin
            AXIS_M_TVALID <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            PKT_CNT <= '0;
        else if (AXIS_M_TVALID && AXIS_M_TREADY && AXIS_M_TLAST)
            PKT_CNT <= PKT_CNT + 1'b1;
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
module tb_axis_rr_arbiter;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int DSTW = 4;
    localparam int IDW  = 2;
    localparam int CW   = 4;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    AXIS_S_TVALID;
    logic [N-1:0]    AXIS_S_TREADY;
    logic [N*DW-1:0] AXIS_S_TDATA;
    logic [N-1:0]    AXIS_S_TLAST;
    logic [N*DSTW-1:0] AXIS_S_TDEST;
    logic            AXIS_M_TVALID;
    logic            AXIS_M_TREADY;
    logic [DW-1:0]   AXIS_M_TDATA;
    logic            AXIS_M_TLAST;
    logic [IDW-1:0]  AXIS_M_TID;
    logic [DSTW-1:0] AXIS_M_TDEST;
    logic [N-1:0]    GRANT;
    logic            BUSY;
    logic [CW-1:0]   PKT_CNT;

    axis_rr_arbiter #(
        .NUM_IN (N),
        .TDATAW (DW),
        .TDESTW (DSTW),
        .TIDW   (IDW),
        .CNTW   (CW)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .AXIS_S_TVALID (AXIS_S_TVALID),
        .AXIS_S_TREADY (AXIS_S_TREADY),
        .AXIS_S_TDATA  (AXIS_S_TDATA),
        .AXIS_S_TLAST  (AXIS_S_TLAST),
        .AXIS_S_TDEST  (AXIS_S_TDEST),
        .AXIS_M_TVALID (AXIS_M_TVALID),
        .AXIS_M_TREADY (AXIS_M_TREADY),
        .AXIS_M_TDATA  (AXIS_M_TDATA),
        .AXIS_M_TLAST  (AXIS_M_TLAST),
        .AXIS_M_TID    (AXIS_M_TID),
        .AXIS_M_TDEST  (AXIS_M_TDEST),
        .GRANT         (GRANT),
        .BUSY          (BUSY),
        .PKT_CNT       (PKT_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0]   data;
        logic            last;
        logic [DSTW-1:0] dest;
    } beat_t;

    typedef struct {
        logic [DW-1:0]   data;
        logic            last;
        logic [IDW-1:0]  tid;
        logic [DSTW-1:0] dest;
        int              gap;
    } exp_t;

    typedef struct {
        logic [N-1:0] mask;
        int           n;
        int           ord[4];
    } rr_vec_t;

    beat_t        src_q[N][$];
    exp_t         exp_q[$];
    logic [N-1:0] hold;
    logic         m_rdy;
    int           total = 0;
    int           bad   = 0;
    int           cyc_n = 0;
    int           last_hs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc_n);
        end
    endtask

    task automatic drive();
        logic [N-1:0]      v;
        logic [N-1:0]      l;
        logic [N*DW-1:0]   d;
        logic [N*DSTW-1:0] t;
        v = '0; l = '0; d = '0; t = '0;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0 && !hold[i]) begin
                v[i]               = 1'b1;
                l[i]               = src_q[i][0].last;
                d[i*DW +: DW]      = src_q[i][0].data;
                t[i*DSTW +: DSTW]  = src_q[i][0].dest;
            end
        end
        AXIS_S_TVALID = v;
        AXIS_S_TLAST  = l;
        AXIS_S_TDATA  = d;
        AXIS_S_TDEST  = t;
        AXIS_M_TREADY = m_rdy;
    endtask

    // Observe at the falling edge (values seen by the next rising edge),
    // then advance requester queues and drive new inputs just after it.
    task automatic cyc();
        logic [N-1:0] hs;
        exp_t         e;
        @(negedge CLK);
        if (AXIS_M_TVALID && AXIS_M_TREADY) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got beat %0h expected none", AXIS_M_TDATA);
            end else begin
                e = exp_q.pop_front();
                chk("m_tdata", AXIS_M_TDATA, e.data);
                chk("m_tlast", 32'(AXIS_M_TLAST), 32'(e.last));
                chk("m_tid",   32'(AXIS_M_TID),   32'(e.tid));
                chk("m_tdest", 32'(AXIS_M_TDEST), 32'(e.dest));
                if (e.gap > 0) chk("m_beat_gap", 32'(cyc_n - last_hs), 32'(e.gap));
            end
            last_hs = cyc_n;
        end
        hs = AXIS_S_TVALID & AXIS_S_TREADY;
        @(posedge CLK);
        #1;
        cyc_n++;
        for (int i = 0; i < N; i++)
            if (hs[i]) void'(src_q[i].pop_front());
        drive();
    endtask

    task automatic add_pkt(input int src, input int len, input int tag,
                           input int gap_first, input int gap_rest);
        beat_t b;
        exp_t  e;
        for (int k = 0; k < len; k++) begin
            b.data = {8'(tag), 8'(src), 8'(k), 8'h5A};
            b.last = (k == len - 1);
            b.dest = 4'(src + tag);
            src_q[src].push_back(b);
            e.data = b.data;
            e.last = b.last;
            e.dest = b.dest;
            e.tid  = 2'(src);
            e.gap  = (k == 0) ? gap_first : gap_rest;
            exp_q.push_back(e);
        end
        drive();
    endtask

    function automatic int pending();
        int p;
        p = exp_q.size();
        for (int i = 0; i < N; i++) p += src_q[i].size();
        return p;
    endfunction

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (pending() != 0 && n < 300) begin
            cyc();
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL %s_drain_timeout: got %0d beats outstanding expected 0", nm, pending());
        end
        cyc();
        chk({nm, "_idle_valid"}, 32'(AXIS_M_TVALID), 32'd0);
    endtask

    task automatic wait_grant(input string nm, input logic [N-1:0] req);
        int w;
        w = 0;
        while (GRANT == '0 && w < 20) begin
            cyc();
            w++;
        end
        chk({nm, "_grant"}, 32'(GRANT), 32'(req));
        chk({nm, "_busy"},  32'(BUSY),  32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rr_vec_t vt[7];
        int      w;

        // Hand-derived order for single-beat packets from each mask, with
        // the priority pointer carried over from the previous row.
        vt[0] = '{4'b1111, 4, '{0, 1, 2, 3}};   // ptr 0 -> 0
        vt[1] = '{4'b0001, 1, '{0, 0, 0, 0}};   // ptr 0 -> 1
        vt[2] = '{4'b1001, 2, '{3, 0, 0, 0}};   // ptr 1 -> 1
        vt[3] = '{4'b0110, 2, '{1, 2, 0, 0}};   // ptr 1 -> 3
        vt[4] = '{4'b0111, 3, '{0, 1, 2, 0}};   // ptr 3 -> 3
        vt[5] = '{4'b1010, 2, '{3, 1, 0, 0}};   // ptr 3 -> 2
        vt[6] = '{4'b1111, 4, '{2, 3, 0, 1}};   // ptr 2 -> 2

        RST   = 1'b1;
        hold  = '0;
        m_rdy = 1'b1;
        drive();
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_m_tvalid", 32'(AXIS_M_TVALID), 32'd0);
        chk("rst_grant",    32'(GRANT),         32'd0);
        chk("rst_busy",     32'(BUSY),          32'd0);
        chk("rst_s_tready", 32'(AXIS_S_TREADY), 32'd0);
        chk("rst_pkt_cnt",  32'(PKT_CNT),       32'd0);
        chk("rst_m_tdata",  AXIS_M_TDATA,       32'd0);
        chk("rst_m_tid",    32'(AXIS_M_TID),    32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        drive();
        cyc();

        for (int r = 0; r < 7; r++) begin
            for (int j = 0; j < vt[r].n; j++)
                add_pkt(vt[r].ord[j], 1, r, (j == 0) ? 0 : 2, 0);
            wait_grant("rr_tbl", N'(1) << vt[r].ord[0]);
            drain("rr_tbl");
        end
        chk("pkt_cnt_table", 32'(PKT_CNT), 32'd2);   // 18 packets mod 16

        // Multi-beat lock: req0 owns the sink for 3 beats while req1 waits.
        add_pkt(0, 3, 10, 0, 1);
        add_pkt(1, 1, 11, 2, 0);
        wait_grant("lock", 4'b0001);
        drain("lock");

        // Owner stalls mid-packet; grant must not move to req0.
        add_pkt(2, 3, 20, 0, 0);
        add_pkt(0, 1, 21, 2, 0);
        wait_grant("stall_src", 4'b0100);
        cyc();
        hold[2] = 1'b1;
        drive();
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_src_grant",   32'(GRANT),         32'h4);
            chk("stall_src_busy",    32'(BUSY),          32'd1);
            chk("stall_src_s_ready", 32'(AXIS_S_TREADY & 4'b1011), 32'd0);
        end
        hold = '0;
        drive();
        drain("stall_src");

        // Sink backpressure: first beat must stay put, no further beat taken.
        m_rdy = 1'b0;
        add_pkt(1, 4, 30, 0, 0);
        w = 0;
        while (!AXIS_M_TVALID && w < 20) begin
            cyc();
            w++;
        end
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("stall_m_valid",  32'(AXIS_M_TVALID), 32'd1);
            chk("stall_m_data",   AXIS_M_TDATA,       {8'd30, 8'd1, 8'd0, 8'h5A});
            chk("stall_s_tready", 32'(AXIS_S_TREADY), 32'd0);
        end
        m_rdy = 1'b1;
        drive();
        drain("stall_m");
        chk("pkt_cnt_pre_rst", 32'(PKT_CNT), 32'd7);   // 23 packets mod 16

        // Reset in the middle of a packet from req3 (pointer was 2).
        add_pkt(3, 4, 40, 0, 0);
        wait_grant("pre_rst", 4'b1000);
        cyc();
        cyc();
        RST = 1'b1;
        exp_q.delete();
        for (int i = 0; i < N; i++) src_q[i].delete();
        drive();
        @(negedge CLK);
        chk("mid_rst_m_tvalid", 32'(AXIS_M_TVALID), 32'd0);
        chk("mid_rst_grant",    32'(GRANT),         32'd0);
        chk("mid_rst_pkt_cnt",  32'(PKT_CNT),       32'd0);
        chk("mid_rst_busy",     32'(BUSY),          32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        drive();
        // Pointer back at 0 means req1 beats req3.
        add_pkt(1, 1, 50, 0, 0);
        add_pkt(3, 1, 51, 2, 0);
        wait_grant("post_rst", 4'b0010);
        drain("post_rst");
        chk("pkt_cnt_post_rst", 32'(PKT_CNT), 32'd2);

        // Counter wrap with a 4-bit counter.
        for (int p = 0; p < 13; p++) add_pkt(0, 1, 60 + p, (p == 0) ? 0 : 2, 0);
        drain("wrap");
        chk("pkt_cnt_15", 32'(PKT_CNT), 32'd15);
        add_pkt(2, 1, 80, 0, 0);
        drain("wrap16");
        chk("pkt_cnt_wrap0", 32'(PKT_CNT), 32'd0);
        add_pkt(3, 1, 81, 0, 0);
        drain("wrap17");
        chk("pkt_cnt_17", 32'(PKT_CNT), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
